// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage after execute.
// Passes ALU results through to writeback with one cycle of latency, and
// performs word loads/stores against an internal data memory that takes
// MEM_LAT cycles per access. While an access is in flight, delay is raised so
// execute holds its output register.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   EXResult   - execute bundle {valid, opcode[3:0], dest[4:0], answer[31:0], value[31:0]}
//   MEMResult  - registered writeback bundle {valid, opcode[3:0], dest[4:0], data[31:0]}
//   MEMDest    - destination register owned by this stage, 0 when none (combinational)
//   delay      - stall to upstream, high while BUSY (combinational from state)
module mem_stage #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [73:0] EXResult,
    output logic [41:0] MEMResult,
    output logic [4:0]  MEMDest,
    output logic        delay
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [3:0]  OP_LW = 4'b1000;
    localparam logic [3:0]  OP_SW = 4'b1001;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          lat_op;
    logic [4:0]          lat_dest;
    logic [ADDR_W-1:0]   lat_addr;
    logic [31:0]         lat_value;
    logic [31:0]         mem [DEPTH];

    // Input bundle fields
    logic        in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_dest;
    logic [31:0] in_answer;
    logic [31:0] in_value;
    logic        in_is_mem;
    logic        done;

    assign in_valid  = EXResult[73];
    assign in_op     = EXResult[72:69];
    assign in_dest   = EXResult[68:64];
    assign in_answer = EXResult[63:32];
    assign in_value  = EXResult[31:0];
    assign in_is_mem = (in_op == OP_LW) || (in_op == OP_SW);
    assign done      = (state == BUSY) && (cnt == '0);

    assign delay = (state == BUSY);

    // Destination owned for hazard checks: stores never own a register
    always_comb begin
        MEMDest = 5'd0;
        if (state == BUSY) begin
            if (lat_op == OP_LW) MEMDest = lat_dest;
        end else if (in_valid && (in_op != OP_SW)) begin
            MEMDest = in_dest;
        end
    end

    // Stage FSM and registered writeback bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            MEMResult <= '0;
            lat_op    <= '0;
            lat_dest  <= '0;
            lat_addr  <= '0;
            lat_value <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_is_mem) begin
                        lat_op    <= in_op;
                        lat_dest  <= in_dest;
                        lat_addr  <= in_answer[ADDR_W-1:0];
                        lat_value <= in_value;
                        cnt       <= CNT_W'(MEM_LAT - 1);
                        MEMResult <= '0;
                        state     <= BUSY;
                    end else if (in_valid) begin
                        MEMResult <= {1'b1, in_op, in_dest, in_answer};
                    end else begin
                        MEMResult <= '0;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt       <= cnt - CNT_W'(1);
                        MEMResult <= '0;
                    end else begin
                        if (lat_op == OP_LW) begin
                            MEMResult <= {1'b1, OP_LW, lat_dest, mem[lat_addr]};
                        end else begin
                            MEMResult <= {1'b1, OP_SW, 5'd0, 32'd0};
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store commits only at completion; reset aborts a pending store
    always_ff @(posedge clk) begin
        if (!reset && done && (lat_op == OP_SW)) begin
            mem[lat_addr] <= lat_value;
        end
    end

endmodule
